// File: rtl/y86_dmem_pkg.sv
// Shared types and constants for the Y86 data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W        = 64;
    localparam int ADDR_W        = 64;
    localparam int MEM_BYTES_DEF = 1024;

    // Y86 icodes of the instructions that touch data memory
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-wide storage with one 8-byte little-endian read port and write port.
// Latency: read is combinational, write lands on the clock edge with i_we.
// Backpressure: none; caller guarantees the 8-byte window is in range when writing.
module y86_dmem_array #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    // Not reset: contents survive a reset of the responder
    logic [7:0] r_mem [MEM_BYTES];

    // Write the eight bytes, lowest byte at the lowest address
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i_addr + AW'(i)] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Gather the eight bytes starting at i_addr, little-endian
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            o_rdata[8*i +: 8] = r_mem[i_addr + AW'(i)];
        end
    end

endmodule

// File: rtl/y86_dmem_responder.sv
// Data-memory responder for the SEQ Y86 memory stage; optional DMEM_ALIGN_CHECK_EN flags unaligned addresses.
// Latency: response valid LATENCY+1 cycles after the accept cycle (counting the accept cycle).
// Backpressure: one transaction in flight; req_ready low until the response is consumed, response held until rsp_ready.
module y86_dmem_responder
    import y86_dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int LATENCY   = 2,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_error;

    logic               w_accept;
    logic               w_commit;
    logic               w_c_write;
    logic [ADDR_W-1:0]  w_c_addr;
    logic [DATA_W-1:0]  w_c_wdata;
    logic               w_range_err;
    logic               w_err;
    logic               w_we;
    logic [DATA_W-1:0]  w_rd;

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    // With zero latency the commit happens on the accept edge, so it must use the live request
    assign w_c_write = (r_state == IDLE) ? req_write : r_write;
    assign w_c_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    // 65-bit sum so addresses near 2^64 cannot wrap into range
    assign w_range_err = ({1'b0, w_c_addr} + 65'd7) > 65'(MEM_BYTES - 1);
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = w_range_err || (w_c_addr[2:0] != 3'd0);
`else
    assign w_err = w_range_err;
`endif

    // A reset on the commit edge wins: nothing is written
    assign w_we = w_commit && w_c_write && !w_err && !reset;

    y86_dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_c_addr[AW-1:0]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_rd)
    );

    // Next-state and commit strobe
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the request and load/run the wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY != 0) begin
                r_cnt <= CNT_W'(LATENCY - 1);
            end
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture the response at commit and hold it until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_commit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (w_c_write || w_err) ? '0 : w_rd;
            r_rsp_error <= w_err;
        end else if (r_state == RESP && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
